// File: rtl/spi_master_cfg.sv
// spi_master_cfg: mode-configurable SPI master with programmable SCLK divider,
// multiple chip selects and multi-word bursts (chip select held between words).
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting
// for both MOSI and MISO. When it is not defined, words are sent MSB first.

module spi_master_cfg #(
   parameter int BUS_WIDTH         = 8,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int NUM_CS            = 2,
   parameter int CS_SEL_W          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic [1:0]           i_Mode,
   input  logic [CS_SEL_W-1:0]  i_CS_Sel,
   input  logic                 i_TX_DV,
   input  logic [BUS_WIDTH-1:0] i_TX_Byte,
   input  logic                 i_TX_Last,
   output logic                 o_TX_Ready,
   output logic                 o_RX_DV,
   output logic [BUS_WIDTH-1:0] o_RX_Byte,
   output logic                 o_SPI_Clk,
   output logic                 o_SPI_MOSI,
   input  logic                 i_SPI_MISO,
   output logic [NUM_CS-1:0]    o_SPI_CS_n
);

   localparam int HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam int EDGE_W = $clog2(2 * BUS_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      WAIT,
      HOLD
   } state_t;

   state_t                r_State;
   logic                  r_Cpol;
   logic                  r_Cpha;
   logic                  r_Last;
   logic [BUS_WIDTH-1:0]  r_TxShift;
   logic [BUS_WIDTH-1:0]  r_RxShift;
   logic [HALF_W-1:0]     r_HalfCnt;
   logic [EDGE_W-1:0]     r_EdgeCnt;
   logic                  r_TxReady;
   logic                  r_RxDv;
   logic [BUS_WIDTH-1:0]  r_RxByte;
   logic                  r_SpiClk;
   logic                  r_SpiMosi;
   logic [NUM_CS-1:0]     r_CS_n;

   logic                  w_Accept;
   logic                  w_HalfDone;
   logic                  w_Leading;
   logic                  w_FinalEdge;
   logic                  w_AccFirst;
   logic [BUS_WIDTH-1:0]  w_AccRest;
   logic                  w_ShFirst;
   logic [BUS_WIDTH-1:0]  w_ShRest;
   logic [BUS_WIDTH-1:0]  w_RxNext;
   logic [NUM_CS-1:0]     w_CsDecode;

   assign w_Accept    = i_TX_DV & r_TxReady;
   assign w_HalfDone  = (r_HalfCnt == HALF_W'(CLKS_PER_HALF_BIT - 1));
   assign w_Leading   = ~r_EdgeCnt[0];
   assign w_FinalEdge = (r_EdgeCnt == EDGE_W'(2 * BUS_WIDTH - 1));

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign w_AccFirst = i_TX_Byte[0];
   assign w_AccRest  = {1'b0, i_TX_Byte[BUS_WIDTH-1:1]};
   assign w_ShFirst  = r_TxShift[0];
   assign w_ShRest   = {1'b0, r_TxShift[BUS_WIDTH-1:1]};
   assign w_RxNext   = {i_SPI_MISO, r_RxShift[BUS_WIDTH-1:1]};
`else
   assign w_AccFirst = i_TX_Byte[BUS_WIDTH-1];
   assign w_AccRest  = {i_TX_Byte[BUS_WIDTH-2:0], 1'b0};
   assign w_ShFirst  = r_TxShift[BUS_WIDTH-1];
   assign w_ShRest   = {r_TxShift[BUS_WIDTH-2:0], 1'b0};
   assign w_RxNext   = {r_RxShift[BUS_WIDTH-2:0], i_SPI_MISO};
`endif

   // Chip-select pattern for the requested index; an out-of-range index
   // leaves every line deasserted so the transfer runs with no slave selected.
   always_comb begin
      w_CsDecode = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (i_CS_Sel == CS_SEL_W'(i)) begin
            w_CsDecode[i] = 1'b0;
         end
      end
   end

   // Burst sequencer: IDLE -> SETUP -> XFER -> (WAIT -> XFER)* -> HOLD -> IDLE,
   // with every pin and handshake output registered here.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State   <= IDLE;
         r_Cpol    <= 1'b0;
         r_Cpha    <= 1'b0;
         r_Last    <= 1'b0;
         r_TxShift <= '0;
         r_RxShift <= '0;
         r_HalfCnt <= '0;
         r_EdgeCnt <= '0;
         r_TxReady <= 1'b1;
         r_RxDv    <= 1'b0;
         r_RxByte  <= '0;
         r_SpiClk  <= 1'b0;
         r_SpiMosi <= 1'b0;
         r_CS_n    <= '1;
      end else begin
         r_RxDv <= 1'b0;
         case (r_State)
            IDLE: begin
               r_TxReady <= 1'b1;
               r_CS_n    <= '1;
               r_SpiClk  <= i_Mode[1];
               if (w_Accept) begin
                  r_Cpol    <= i_Mode[1];
                  r_Cpha    <= i_Mode[0];
                  r_Last    <= i_TX_Last;
                  r_CS_n    <= w_CsDecode;
                  r_TxReady <= 1'b0;
                  r_HalfCnt <= '0;
                  r_EdgeCnt <= '0;
                  r_RxShift <= '0;
                  if (!i_Mode[0]) begin
                     r_SpiMosi <= w_AccFirst;
                     r_TxShift <= w_AccRest;
                  end else begin
                     r_TxShift <= i_TX_Byte;
                  end
                  r_State <= SETUP;
               end
            end

            SETUP: begin
               if (w_HalfDone) begin
                  r_HalfCnt <= '0;
                  r_State   <= XFER;
               end else begin
                  r_HalfCnt <= r_HalfCnt + HALF_W'(1);
               end
            end

            XFER: begin
               if (!w_HalfDone) begin
                  r_HalfCnt <= r_HalfCnt + HALF_W'(1);
               end else begin
                  r_HalfCnt <= '0;
                  r_SpiClk  <= ~r_SpiClk;
                  r_EdgeCnt <= r_EdgeCnt + EDGE_W'(1);
                  if (w_Leading) begin
                     if (!r_Cpha) begin
                        r_RxShift <= w_RxNext;
                     end else begin
                        r_SpiMosi <= w_ShFirst;
                        r_TxShift <= w_ShRest;
                     end
                  end else begin
                     if (r_Cpha) begin
                        r_RxShift <= w_RxNext;
                     end else if (!w_FinalEdge) begin
                        r_SpiMosi <= w_ShFirst;
                        r_TxShift <= w_ShRest;
                     end
                  end
                  if (w_FinalEdge) begin
                     r_RxByte  <= r_Cpha ? w_RxNext : r_RxShift;
                     r_RxDv    <= 1'b1;
                     r_EdgeCnt <= '0;
                     if (r_Last) begin
                        r_State <= HOLD;
                     end else begin
                        r_TxReady <= 1'b1;
                        r_State   <= WAIT;
                     end
                  end
               end
            end

            WAIT: begin
               r_SpiClk <= r_Cpol;
               if (w_Accept) begin
                  r_TxReady <= 1'b0;
                  r_Last    <= i_TX_Last;
                  r_HalfCnt <= '0;
                  r_EdgeCnt <= '0;
                  r_RxShift <= '0;
                  if (!r_Cpha) begin
                     r_SpiMosi <= w_AccFirst;
                     r_TxShift <= w_AccRest;
                  end else begin
                     r_TxShift <= i_TX_Byte;
                  end
                  r_State <= XFER;
               end
            end

            HOLD: begin
               if (w_HalfDone) begin
                  r_HalfCnt <= '0;
                  r_CS_n    <= '1;
                  r_TxReady <= 1'b1;
                  r_State   <= IDLE;
               end else begin
                  r_HalfCnt <= r_HalfCnt + HALF_W'(1);
               end
            end

            default: begin
               r_State <= IDLE;
            end
         endcase
      end
   end

   assign o_TX_Ready = r_TxReady;
   assign o_RX_DV    = r_RxDv;
   assign o_RX_Byte  = r_RxByte;
   assign o_SPI_Clk  = r_SpiClk;
   assign o_SPI_MOSI = r_SpiMosi;
   assign o_SPI_CS_n = r_CS_n;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: table-driven single-word transfers
// against a behavioural SPI slave (or MOSI->MISO loopback), plus hand-written
// burst, ignored-request and mid-transfer reset sequences. Received words are
// checked through a scoreboard queue filled when each word is driven.

module tb_spi_master_cfg;

   localparam int W      = 8;
   localparam int H      = 2;
   localparam int NCS    = 2;
   localparam int CSW    = 1;
   localparam int DV_LAT  = H + 2 * W * H + 1;
   localparam int RDY_LAT = 2 * H + 2 * W * H + 1;

   logic           i_Clk = 1'b0;
   logic           i_Rst_L = 1'b0;
   logic [1:0]     i_Mode = 2'd0;
   logic [CSW-1:0] i_CS_Sel = '0;
   logic           i_TX_DV = 1'b0;
   logic [W-1:0]   i_TX_Byte = '0;
   logic           i_TX_Last = 1'b0;
   logic           o_TX_Ready;
   logic           o_RX_DV;
   logic [W-1:0]   o_RX_Byte;
   logic           o_SPI_Clk;
   logic           o_SPI_MOSI;
   logic           i_SPI_MISO;
   logic [NCS-1:0] o_SPI_CS_n;

   typedef struct {
      logic [1:0]     mode;
      logic [CSW-1:0] csSel;
      logic [W-1:0]   txByte;
      logic [W-1:0]   slaveByte;
      logic           loop;
      logic [W-1:0]   expRx;
   } vec_t;

   vec_t         vecs[$];
   logic [W-1:0] expQ[$];

   int checks = 0;
   int passed = 0;
   int cycleCnt = 0;
   int acceptCycle = 0;
   int rxDvCount = 0;
   int sclkRise = 0;
   logic prevSclkMon = 1'b0;
   logic burstWatch = 1'b0;
   logic csBreak = 1'b0;
   logic cs0Low = 1'b0;

   logic         loopMode = 1'b1;
   logic         slvMiso = 1'b0;
   logic         slvCpol = 1'b0;
   logic         slvCpha = 1'b0;
   logic [W-1:0] slvTx = '0;
   logic [W-1:0] slvMosiWord = '0;
   logic [W-1:0] slvRxWord = '0;
   logic         slvActive = 1'b0;
   logic         slvPrevSclk = 1'b0;
   int           slvEdges = 0;
   int           slvBit = 0;
   int           slvSIdx = 0;

   assign i_SPI_MISO = loopMode ? o_SPI_MOSI : slvMiso;

   spi_master_cfg #(
      .BUS_WIDTH(W),
      .CLKS_PER_HALF_BIT(H),
      .NUM_CS(NCS),
      .CS_SEL_W(CSW)
   ) dut (
      .i_Clk(i_Clk),
      .i_Rst_L(i_Rst_L),
      .i_Mode(i_Mode),
      .i_CS_Sel(i_CS_Sel),
      .i_TX_DV(i_TX_DV),
      .i_TX_Byte(i_TX_Byte),
      .i_TX_Last(i_TX_Last),
      .o_TX_Ready(o_TX_Ready),
      .o_RX_DV(o_RX_DV),
      .o_RX_Byte(o_RX_Byte),
      .o_SPI_Clk(o_SPI_Clk),
      .o_SPI_MOSI(o_SPI_MOSI),
      .i_SPI_MISO(i_SPI_MISO),
      .o_SPI_CS_n(o_SPI_CS_n)
   );

   // 100 MHz system clock
   always #5 i_Clk = ~i_Clk;

   // Free-running cycle counter used for latency measurements
   always @(posedge i_Clk) cycleCnt <= cycleCnt + 1;

   // Hard stop in case the DUT wedges and some wait is never satisfied
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Position inside a word of the idx-th bit on the wire
   function automatic int bitPos(int idx);
`ifdef SPI_MASTER_LSB_FIRST_EN
      return idx;
`else
      return W - 1 - idx;
`endif
   endfunction

   // Single comparison point: every check in the bench funnels through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Behavioural slave: presents slvTx on MISO on its launch edges and
   // captures MOSI on its sample edges, following the CPOL/CPHA rules
   initial begin
      forever begin
         @(negedge i_Clk);
         if (!i_Rst_L) begin
            slvActive = 1'b0;
         end else if (o_SPI_CS_n != '1 && !slvActive) begin
            slvActive   = 1'b1;
            slvEdges    = 0;
            slvSIdx     = 0;
            slvMosiWord = '0;
            if (!slvCpha) begin
               slvMiso = slvTx[bitPos(0)];
               slvBit  = 1;
            end else begin
               slvBit = 0;
            end
         end else if (o_SPI_CS_n != '1 && o_SPI_Clk != slvPrevSclk) begin
            if (o_SPI_Clk != slvCpol) begin
               if (!slvCpha) begin
                  slvMosiWord[bitPos(slvSIdx)] = o_SPI_MOSI;
                  slvSIdx++;
               end else begin
                  slvMiso = slvTx[bitPos(slvBit)];
                  slvBit++;
               end
            end else begin
               if (slvCpha) begin
                  slvMosiWord[bitPos(slvSIdx)] = o_SPI_MOSI;
                  slvSIdx++;
               end else if (slvEdges != 2 * W - 1) begin
                  slvMiso = slvTx[bitPos(slvBit)];
                  slvBit++;
               end
            end
            slvEdges++;
            if (slvEdges == 2 * W) begin
               slvRxWord   = slvMosiWord;
               slvMosiWord = '0;
               slvEdges    = 0;
               slvSIdx     = 0;
               if (!slvCpha) begin
                  slvMiso = slvTx[bitPos(0)];
                  slvBit  = 1;
               end else begin
                  slvBit = 0;
               end
            end
         end else if (o_SPI_CS_n == '1) begin
            slvActive = 1'b0;
         end
         slvPrevSclk = o_SPI_Clk;
      end
   end

   // Output monitor: pops the scoreboard on every RX_DV pulse, counts SCLK
   // rising edges while a slave is selected and watches CS during bursts
   initial begin
      forever begin
         @(negedge i_Clk);
         if (o_RX_DV) begin
            rxDvCount++;
            if (expQ.size() == 0) checkOutput("rx_unexpected_dv", 32'd1, 32'd0);
            else checkOutput("rx_byte", 32'(o_RX_Byte), 32'(expQ.pop_front()));
         end
         if (o_SPI_CS_n != '1 && o_SPI_Clk && !prevSclkMon) sclkRise++;
         if (burstWatch) begin
            if (o_SPI_CS_n[1]) csBreak = 1'b1;
            if (!o_SPI_CS_n[0]) cs0Low = 1'b1;
         end
         prevSclkMon = o_SPI_Clk;
      end
   end

   // Offer one word: settle mode/CS select, wait (bounded) for ready, then
   // hold TX_DV for exactly the accept cycle and queue the expected RX word
   task automatic applyStimulus(input logic [1:0] mode, input logic [CSW-1:0] sel,
                                input logic [W-1:0] tx, input logic last, input logic [W-1:0] expRx);
      i_Mode   = mode;
      i_CS_Sel = sel;
      repeat (2) @(negedge i_Clk);
      for (int c = 0; c < 500 && !o_TX_Ready; c++) @(negedge i_Clk);
      if (!o_TX_Ready) checkOutput("ready_timeout", 32'd0, 32'd1);
      i_TX_DV     = 1'b1;
      i_TX_Byte   = tx;
      i_TX_Last   = last;
      acceptCycle = cycleCnt;
      sclkRise    = 0;
      expQ.push_back(expRx);
      @(negedge i_Clk);
      i_TX_DV   = 1'b0;
      i_TX_Last = 1'b0;
   endtask

   // Bounded wait until the DUT reports ready again
   task automatic waitReady();
      for (int c = 0; c < 500 && !o_TX_Ready; c++) @(negedge i_Clk);
      if (!o_TX_Ready) checkOutput("ready_return_timeout", 32'd0, 32'd1);
   endtask

   // One complete single-word transfer from the vector table with timing,
   // pin-state and slave-side checks
   task automatic runVector(input vec_t v);
      int dvLat;
      int rdyLat;
      int startDv;
      logic [NCS-1:0] expCs;
      loopMode = v.loop;
      slvTx    = v.slaveByte;
      slvCpol  = v.mode[1];
      slvCpha  = v.mode[0];
      startDv  = rxDvCount;
      expCs    = '1;
      expCs[v.csSel] = 1'b0;
      applyStimulus(v.mode, v.csSel, v.txByte, 1'b1, v.expRx);
      checkOutput("cs_active", 32'(o_SPI_CS_n), 32'(expCs));
      checkOutput("ready_drop", 32'(o_TX_Ready), 32'd0);
      dvLat  = -1;
      rdyLat = -1;
      for (int c = 0; c < 200 && rdyLat < 0; c++) begin
         @(negedge i_Clk);
         if (o_RX_DV && dvLat < 0) dvLat = cycleCnt - acceptCycle;
         if (o_TX_Ready && rdyLat < 0) rdyLat = cycleCnt - acceptCycle;
      end
      checkOutput("rx_dv_latency", 32'(dvLat), 32'(DV_LAT));
      checkOutput("ready_latency", 32'(rdyLat), 32'(RDY_LAT));
      checkOutput("sclk_idle_cpol", 32'(o_SPI_Clk), 32'(v.mode[1]));
      checkOutput("cs_idle", 32'(o_SPI_CS_n), 32'h3);
      checkOutput("sclk_rises", 32'(sclkRise), 32'(W));
      checkOutput("slave_mosi_word", 32'(slvRxWord), 32'(v.txByte));
      checkOutput("rx_byte_held", 32'(o_RX_Byte), 32'(v.expRx));
      checkOutput("rx_dv_pulses", 32'(rxDvCount - startDv), 32'd1);
   endtask

   // Main sequence
   initial begin
      int startDv;
      vec_t v;

      // mode, csSel, tx, slave data, loopback, expected RX
      vecs.push_back('{2'd0, 1'b0, 8'hA5, 8'h00, 1'b1, 8'hA5});
      vecs.push_back('{2'd1, 1'b0, 8'h3C, 8'hC3, 1'b0, 8'hC3});
      vecs.push_back('{2'd2, 1'b1, 8'h3C, 8'hC3, 1'b0, 8'hC3});
      vecs.push_back('{2'd3, 1'b1, 8'h3C, 8'hC3, 1'b0, 8'hC3});
      vecs.push_back('{2'd0, 1'b0, 8'h12, 8'h9E, 1'b0, 8'h9E});
      vecs.push_back('{2'd3, 1'b0, 8'h2D, 8'hB1, 1'b0, 8'hB1});
      vecs.push_back('{2'd1, 1'b1, 8'hE8, 8'h00, 1'b1, 8'hE8});
      vecs.push_back('{2'd0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01});

      // Reset state
      repeat (3) @(negedge i_Clk);
      checkOutput("reset_ready", 32'(o_TX_Ready), 32'd1);
      checkOutput("reset_rx_dv", 32'(o_RX_DV), 32'd0);
      checkOutput("reset_rx_byte", 32'(o_RX_Byte), 32'd0);
      checkOutput("reset_sclk", 32'(o_SPI_Clk), 32'd0);
      checkOutput("reset_mosi", 32'(o_SPI_MOSI), 32'd0);
      checkOutput("reset_cs", 32'(o_SPI_CS_n), 32'h3);
      i_Rst_L = 1'b1;
      repeat (2) @(negedge i_Clk);

      // Table-driven single-word transfers
      foreach (vecs[i]) begin
         $display("[TB] vector %0d mode %0d tx 0x%0h", i, vecs[i].mode, vecs[i].txByte);
         runVector(vecs[i]);
      end

      // Three-word burst on CS 1: CS must stay low across all words
      $display("[TB] burst sequence");
      loopMode = 1'b1;
      slvCpol  = 1'b0;
      slvCpha  = 1'b0;
      startDv  = rxDvCount;
      csBreak  = 1'b0;
      cs0Low   = 1'b0;
      applyStimulus(2'd0, 1'b1, 8'h11, 1'b0, 8'h11);
      burstWatch = 1'b1;
      applyStimulus(2'd0, 1'b1, 8'h22, 1'b0, 8'h22);
      applyStimulus(2'd0, 1'b1, 8'h33, 1'b1, 8'h33);
      for (int c = 0; c < 300 && rxDvCount < startDv + 3; c++) @(negedge i_Clk);
      burstWatch = 1'b0;
      checkOutput("burst_rx_dv_pulses", 32'(rxDvCount - startDv), 32'd3);
      checkOutput("burst_cs1_held_low", 32'(csBreak), 32'd0);
      checkOutput("burst_cs0_stays_high", 32'(cs0Low), 32'd0);
      waitReady();
      checkOutput("burst_cs_idle", 32'(o_SPI_CS_n), 32'h3);

      // A request while busy is ignored and does not corrupt the word in flight
      $display("[TB] ignored request sequence");
      startDv = rxDvCount;
      applyStimulus(2'd0, 1'b0, 8'hC6, 1'b1, 8'hC6);
      repeat (10) @(negedge i_Clk);
      i_TX_DV   = 1'b1;
      i_TX_Byte = 8'hFF;
      i_TX_Last = 1'b1;
      repeat (3) @(negedge i_Clk);
      i_TX_DV   = 1'b0;
      i_TX_Last = 1'b0;
      waitReady();
      repeat (40) @(negedge i_Clk);
      checkOutput("ignored_dv_pulses", 32'(rxDvCount - startDv), 32'd1);
      checkOutput("ignored_rx_byte", 32'(o_RX_Byte), 32'hC6);
      checkOutput("ignored_slave_mosi", 32'(slvRxWord), 32'hC6);
      checkOutput("ignored_cs_idle", 32'(o_SPI_CS_n), 32'h3);

      // Reset dropped mid-transfer in mode 3, while SCLK sits high
      $display("[TB] mid-transfer reset sequence");
      slvCpol = 1'b1;
      slvCpha = 1'b1;
      startDv = rxDvCount;
      applyStimulus(2'd3, 1'b0, 8'h77, 1'b1, 8'h77);
      repeat (14) @(negedge i_Clk);
      checkOutput("pre_reset_sclk_high", 32'(o_SPI_Clk), 32'd1);
      #2 i_Rst_L = 1'b0;
      #1;
      checkOutput("async_reset_cs", 32'(o_SPI_CS_n), 32'h3);
      checkOutput("async_reset_sclk", 32'(o_SPI_Clk), 32'd0);
      checkOutput("async_reset_rx_dv", 32'(o_RX_DV), 32'd0);
      checkOutput("async_reset_ready", 32'(o_TX_Ready), 32'd1);
      expQ.delete();
      i_Mode = 2'd0;
      repeat (3) @(negedge i_Clk);
      i_Rst_L = 1'b1;
      repeat (2) @(negedge i_Clk);
      checkOutput("reset_no_rx_dv", 32'(rxDvCount - startDv), 32'd0);
      checkOutput("reset_rx_byte_cleared", 32'(o_RX_Byte), 32'd0);
      v = '{2'd0, 1'b0, 8'h5A, 8'h00, 1'b1, 8'h5A};
      runVector(v);

      repeat (5) @(negedge i_Clk);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
